// File: rtl/music_pkg.sv
// Shared note codes, frequency table and FSM encoding for the melody player.
// half_period() is evaluated only with constant arguments, so no divider is built.
package music_pkg;

    localparam logic [4:0] REST = 5'd0;
    localparam logic [4:0] L1 = 5'd1,  L2 = 5'd2,  L3 = 5'd3,  L4 = 5'd4;
    localparam logic [4:0] L5 = 5'd5,  L6 = 5'd6,  L7 = 5'd7;
    localparam logic [4:0] M1 = 5'd8,  M2 = 5'd9,  M3 = 5'd10, M4 = 5'd11;
    localparam logic [4:0] M5 = 5'd12, M6 = 5'd13, M7 = 5'd14;
    localparam logic [4:0] H1 = 5'd15, H2 = 5'd16, H3 = 5'd17, H4 = 5'd18;
    localparam logic [4:0] H5 = 5'd19, H6 = 5'd20, H7 = 5'd21;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GAP,
        ST_TONE,
        ST_REST
    } state_t;

    // Tone frequency in Hz; 0 marks a rest or an unused code.
    function automatic int unsigned note_freq(input logic [4:0] code);
        case (code)
            L1: return 262;   L2: return 294;   L3: return 330;   L4: return 349;
            L5: return 392;   L6: return 440;   L7: return 494;
            M1: return 524;   M2: return 588;   M3: return 660;   M4: return 698;
            M5: return 784;   M6: return 880;   M7: return 988;
            H1: return 1046;  H2: return 1175;  H3: return 1318;  H4: return 1397;
            H5: return 1568;  H6: return 1760;  H7: return 1976;
            default: return 0;
        endcase
    endfunction

    function automatic int unsigned half_period(input logic [4:0] code,
                                                input int unsigned clk_freq);
        int unsigned f;
        f = note_freq(code);
        return (f == 0) ? 0 : clk_freq / (2 * f);
    endfunction

    function automatic logic is_tone(input logic [4:0] code);
        return (code != REST) && (code <= H7);
    endfunction

endpackage

// File: rtl/note_rom.sv
// Melody ROM: one 5-bit note code per beat index, registered output.
module note_rom
    import music_pkg::*;
#(
    parameter int BEAT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BEAT_W-1:0] addr_i,
    output logic [4:0]        code_o
);

    logic [4:0] code_d;
    logic [4:0] code_q;

    always_comb begin
        code_d = REST;
        case (int'(addr_i))
            0:  code_d = REST;
            1:  code_d = M6;
            2:  code_d = M6;
            3:  code_d = M5;
            4:  code_d = M3;
            5:  code_d = H7;
            6:  code_d = H7;
            7:  code_d = H7;
            8:  code_d = H6;
            9:  code_d = L1;
            10: code_d = L5;
            25: code_d = 5'd25;
            default: code_d = REST;
        endcase
    end

    // NOTE: the song is a constant decode rather than a storage array, so only the
    // output register needs a reset value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_q <= REST;
        end else begin
            code_q <= code_d;
        end
    end

    assign code_o = code_q;

endmodule

// File: rtl/tone_gen.sv
// Beat-indexed melody player: detects beat changes, fetches the note from note_rom
// and drives a 50% square wave, inserting a silent gap between repeated notes.
module tone_gen
    import music_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned GAP_CYCLES = 500_000,
    parameter int          BEAT_W     = 8,
    parameter int          DIV_W      = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [BEAT_W-1:0] beat_cnt,
    output logic              beat_strobe,
    output logic [4:0]        note_code,
    output logic              note_valid,
    output logic              buzzer
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    if (64'(half_period(L1, CLK_FREQ)) >= (64'd1 << DIV_W)) begin : g_div_w_too_narrow
        $error("tone_gen: DIV_W cannot hold the longest half period");
    end

    logic [BEAT_W-1:0] beat_q;
    logic              beat_strobe_q;
    logic              note_load_q;
    logic [4:0]        prev_code_q;
    state_t            state_q,  state_d;
    logic [DIV_W-1:0]  div_q,    div_d;
    logic [GAP_W-1:0]  gap_q,    gap_d;
    logic              buzzer_q, buzzer_d;
    logic [DIV_W-1:0]  half_tab [32];
    logic [DIV_W-1:0]  half_cur;

    for (genvar g = 0; g < 32; g++) begin : g_half
        assign half_tab[g] = DIV_W'(half_period(5'(g), CLK_FREQ));
    end

    note_rom #(.BEAT_W(BEAT_W)) u_rom (
        .clk    (clk),
        .rst    (rst),
        .addr_i (beat_q),
        .code_o (note_code)
    );

    assign note_valid = is_tone(note_code);
    assign half_cur   = half_tab[note_code];

    // NOTE: every output of this block gets a default first, so no path can leave a
    // signal unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        gap_d    = gap_q;
        buzzer_d = buzzer_q;
        if (!en) begin
            state_d  = ST_IDLE;
            div_d    = '0;
            gap_d    = '0;
            buzzer_d = 1'b0;
        end else if (state_q == ST_IDLE || note_load_q) begin
            // A note entry always starts at phase 0; it also beats a divider toggle.
            div_d    = '0;
            gap_d    = '0;
            buzzer_d = 1'b0;
            if (!note_valid) begin
                state_d = ST_REST;
            end else if (state_q != ST_IDLE && note_code == prev_code_q) begin
                state_d = ST_GAP;
            end else begin
                state_d = ST_TONE;
            end
        end else begin
            case (state_q)
                ST_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        state_d = ST_TONE;
                        gap_d   = '0;
                        div_d   = '0;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
                ST_TONE: begin
                    if (div_q == half_cur - 1'b1) begin
                        div_d    = '0;
                        buzzer_d = ~buzzer_q;
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
                default: begin
                    div_d    = '0;
                    gap_d    = '0;
                    buzzer_d = 1'b0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_q        <= '0;
            beat_strobe_q <= 1'b0;
            note_load_q   <= 1'b0;
            prev_code_q   <= REST;
            state_q       <= ST_IDLE;
            div_q         <= '0;
            gap_q         <= '0;
            buzzer_q      <= 1'b0;
        end else begin
            beat_q        <= beat_cnt;
            beat_strobe_q <= (beat_cnt != beat_q);
            note_load_q   <= beat_strobe_q;
            if (beat_strobe_q) begin
                prev_code_q <= note_code;
            end
            state_q       <= state_d;
            div_q         <= div_d;
            gap_q         <= gap_d;
            buzzer_q      <= buzzer_d;
        end
    end

    assign beat_strobe = beat_strobe_q;
    assign buzzer      = buzzer_q;

endmodule

// File: tb/tb_tone_gen.sv
// Directed bench for tone_gen: a vector table for beat detect / ROM / rest cases and
// hand-written sequences for tone timing, repeat gap, enable and reset corners.
module tb_tone_gen;

    localparam int HALF_M6 = 28409;
    localparam int HALF_H7 = 12651;
    localparam int HALF_H6 = 14204;
    localparam int GAP     = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] beat_cnt;
    logic       beat_strobe;
    logic [4:0] note_code;
    logic       note_valid;
    logic       buzzer;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        string      name;
        logic       en;
        logic [7:0] beat;
        int         edges;
        logic       strobe;
        logic [4:0] code;
        logic       valid;
        logic       buz;
    } vec_t;

    vec_t vecs [17];

    tone_gen #(
        .CLK_FREQ   (50_000_000),
        .GAP_CYCLES (GAP),
        .BEAT_W     (8),
        .DIV_W      (18)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .beat_cnt    (beat_cnt),
        .beat_strobe (beat_strobe),
        .note_code   (note_code),
        .note_valid  (note_valid),
        .buzzer      (buzzer)
    );

    always #5 clk = ~clk;

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, got running, required finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input string n, input logic e, input logic [7:0] b,
                                input int ed, input logic s, input logic [4:0] c,
                                input logic v, input logic z);
        vec_t r;
        r.name = n;  r.en = e;    r.beat = b;  r.edges = ed;
        r.strobe = s; r.code = c; r.valid = v; r.buz = z;
        return r;
    endfunction

    task automatic run_vec(input int i);
        en       = vecs[i].en;
        beat_cnt = vecs[i].beat;
        step(vecs[i].edges);
        check({vecs[i].name, ".strobe"}, int'(beat_strobe), int'(vecs[i].strobe));
        check({vecs[i].name, ".code"},   int'(note_code),   int'(vecs[i].code));
        check({vecs[i].name, ".valid"},  int'(note_valid),  int'(vecs[i].valid));
        check({vecs[i].name, ".buzzer"}, int'(buzzer),      int'(vecs[i].buz));
    endtask

    initial begin
        //               name           en beat edges strb code valid buz
        vecs[0]  = mk("rst_idle",      0, 0,   1,    0,   0,   0,   0);
        vecs[1]  = mk("en_rest",       1, 0,   2,    0,   0,   0,   0);
        vecs[2]  = mk("b1_strobe",     1, 1,   1,    1,   0,   0,   0);
        vecs[3]  = mk("b1_code",       1, 1,   1,    0,   13,  1,   0);
        vecs[4]  = mk("b2_strobe",     1, 2,   1,    1,   13,  1,   1);
        vecs[5]  = mk("b2_code",       1, 2,   1,    0,   13,  1,   1);
        vecs[6]  = mk("b2_gap_entry",  1, 2,   1,    0,   13,  1,   0);
        vecs[7]  = mk("b2_gap_hold",   1, 2,   10,   0,   13,  1,   0);
        vecs[8]  = mk("b3_strobe",     1, 3,   1,    1,   13,  1,   0);
        vecs[9]  = mk("b3_code",       1, 3,   1,    0,   12,  1,   0);
        vecs[10] = mk("b25_code",      1, 25,  2,    0,   25,  0,   0);
        vecs[11] = mk("b25_silent",    1, 25,  50,   0,   25,  0,   0);
        vecs[12] = mk("b0_rest",       1, 0,   2,    0,   0,   0,   0);
        vecs[13] = mk("b255_rest",     1, 255, 3,    0,   0,   0,   0);
        vecs[14] = mk("wrap_strobe",   1, 0,   1,    1,   0,   0,   0);
        vecs[15] = mk("wrap_once",     1, 0,   1,    0,   0,   0,   0);
        vecs[16] = mk("wrap_quiet",    1, 0,   5,    0,   0,   0,   0);

        rst = 1'b1; en = 1'b0; beat_cnt = 8'd0;
        step(3);
        check("reset.buzzer", int'(buzzer), 0);
        check("reset.code",   int'(note_code), 0);
        check("reset.valid",  int'(note_valid), 0);
        check("reset.strobe", int'(beat_strobe), 0);
        rst = 1'b0;

        for (int i = 0; i <= 3; i++) run_vec(i);

        // M6 (880 Hz): first rising edge HALF+3 edges after the beat change.
        step(HALF_M6 + 3 - 2 - 1);
        check("m6_before_rise", int'(buzzer), 0);
        step(1);
        check("m6_rise", int'(buzzer), 1);

        for (int i = 4; i <= 16; i++) run_vec(i);

        // Repeated H7: 16-cycle gap, then phase 0.
        beat_cnt = 8'd5;
        step(13);
        check("h7_code", int'(note_code), int'(5'd21));
        beat_cnt = 8'd6;
        step(3 + GAP + HALF_H7 - 1);
        check("h7_gap_before_rise", int'(buzzer), 0);
        step(1);
        check("h7_gap_rise", int'(buzzer), 1);

        // Enable drop mid-tone, then resume from phase 0 with no gap.
        en = 1'b0;
        step(1);
        check("en_off_buzzer", int'(buzzer), 0);
        step(5);
        check("en_off_hold", int'(buzzer), 0);
        en = 1'b1;
        step(1 + HALF_H7 - 1);
        check("en_on_before_rise", int'(buzzer), 0);
        step(1);
        check("en_on_rise", int'(buzzer), 1);

        // Asynchronous reset between clock edges while the buzzer is high.
        #2 rst = 1'b1;
        #1;
        check("async_rst.buzzer", int'(buzzer), 0);
        check("async_rst.code",   int'(note_code), 0);
        check("async_rst.valid",  int'(note_valid), 0);
        check("async_rst.strobe", int'(beat_strobe), 0);
        @(negedge clk);
        rst = 1'b0;
        step(1);
        check("post_rst_buzzer", int'(buzzer), 0);

        // Gap for repeated H7 aborted by a change to H6.
        step(10);
        beat_cnt = 8'd7;
        step(5);
        check("abort_in_gap", int'(buzzer), 0);
        beat_cnt = 8'd8;
        step(2);
        check("abort_code", int'(note_code), int'(5'd20));
        step(HALF_H6 + 3 - 2 - 1);
        check("h6_before_rise", int'(buzzer), 0);
        step(1);
        check("h6_rise", int'(buzzer), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
